tl_mem_port_arbiter: RTL and testbench

- N-way TileLink-UL A/D arbiter that shares the single system memory port between requesters, e.g. L2 refill/writeback engines or per-bank L2 slices.
- A channel: round-robin arbitration, with the grant locked for the full length of multi-beat PutFullData/PutPartialData bursts.
- D channel: beats are routed back to the owning requester by the requester index embedded in the upper bits of d_source.
- Sits between the L2 and the memory port (mem_a_*/mem_d_*).

---
 rtl/tl_mem_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 tb/tb_tl_mem_port_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tl_mem_port_arbiter
//
// Shares one TileLink-UL memory port between N_REQ requesters, for example
// L2 refill/writeback engines or per-bank L2 slices.
//
// A channel: round-robin grant. The grant is held for every beat of a
// multi-beat PutFullData/PutPartialData burst. The winner's index goes into
// the top IDX_W bits of mem_a_source_o.
// D channel: each beat goes back to the requester named by the top IDX_W
// bits of mem_d_source_i. This path keeps no state, so A and D traffic move
// independently of each other.
//
// Build option:
//   TL_ARB_FIXED_PRIO_EN - when defined, the IDLE grant is fixed priority
//                          (lowest index wins) and the round-robin pointer
//                          is not built. Burst locking does not change.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   req_a_*                 per-requester A channel (flattened N_REQ vectors)
//   mem_a_*                 memory-side A channel
//   mem_d_*                 memory-side D channel
//   req_d_valid_o/ready_i   per-requester D handshake
//   req_d_*_o               D payload broadcast to all requesters
//   arb_busy_o              burst lock held
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | free arbitration; a multi-beat Put that fires takes the lock
// ST_BURST | grant held by lock_idx_q until the last beat of the burst fires
// ---------------------------------------------------------------------------
module tl_mem_port_arbiter #(
    parameter int unsigned N_REQ     = 2,
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned SRC_W     = 4,
    parameter int unsigned MAX_BEATS = 8,
    localparam int unsigned IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int unsigned LSRC_W   = SRC_W - IDX_W,
    localparam int unsigned MASK_W   = DATA_W / 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,

    input  logic [N_REQ-1:0]           req_a_valid_i,
    output logic [N_REQ-1:0]           req_a_ready_o,
    input  logic [N_REQ*3-1:0]         req_a_opcode_i,
    input  logic [N_REQ*3-1:0]         req_a_param_i,
    input  logic [N_REQ*3-1:0]         req_a_size_i,
    input  logic [N_REQ*LSRC_W-1:0]    req_a_source_i,
    input  logic [N_REQ*ADDR_W-1:0]    req_a_address_i,
    input  logic [N_REQ*MASK_W-1:0]    req_a_mask_i,
    input  logic [N_REQ*DATA_W-1:0]    req_a_data_i,

    output logic                       mem_a_valid_o,
    input  logic                       mem_a_ready_i,
    output logic [2:0]                 mem_a_opcode_o,
    output logic [2:0]                 mem_a_param_o,
    output logic [2:0]                 mem_a_size_o,
    output logic [SRC_W-1:0]           mem_a_source_o,
    output logic [ADDR_W-1:0]          mem_a_address_o,
    output logic [MASK_W-1:0]          mem_a_mask_o,
    output logic [DATA_W-1:0]          mem_a_data_o,

    input  logic                       mem_d_valid_i,
    output logic                       mem_d_ready_o,
    input  logic [2:0]                 mem_d_opcode_i,
    input  logic [1:0]                 mem_d_param_i,
    input  logic [2:0]                 mem_d_size_i,
    input  logic [SRC_W-1:0]           mem_d_source_i,
    input  logic [1:0]                 mem_d_sink_i,
    input  logic                       mem_d_denied_i,
    input  logic [DATA_W-1:0]          mem_d_data_i,
    input  logic                       mem_d_corrupt_i,

    output logic [N_REQ-1:0]           req_d_valid_o,
    input  logic [N_REQ-1:0]           req_d_ready_i,
    output logic [2:0]                 req_d_opcode_o,
    output logic [1:0]                 req_d_param_o,
    output logic [2:0]                 req_d_size_o,
    output logic [LSRC_W-1:0]          req_d_source_o,
    output logic [1:0]                 req_d_sink_o,
    output logic                       req_d_denied_o,
    output logic [DATA_W-1:0]          req_d_data_o,
    output logic                       req_d_corrupt_o,

    output logic                       arb_busy_o
);

    localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
`ifndef TL_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
`endif

    // Per-requester views of the flattened payload buses.
    logic [N_REQ-1:0][2:0]        a_opcode;
    logic [N_REQ-1:0][2:0]        a_param;
    logic [N_REQ-1:0][2:0]        a_size;
    logic [N_REQ-1:0][LSRC_W-1:0] a_source;
    logic [N_REQ-1:0][ADDR_W-1:0] a_address;
    logic [N_REQ-1:0][MASK_W-1:0] a_mask;
    logic [N_REQ-1:0][DATA_W-1:0] a_data;

    assign a_opcode  = req_a_opcode_i;
    assign a_param   = req_a_param_i;
    assign a_size    = req_a_size_i;
    assign a_source  = req_a_source_i;
    assign a_address = req_a_address_i;
    assign a_mask    = req_a_mask_i;
    assign a_data    = req_a_data_i;

    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   cand;
    logic               sel_hit;
    logic               a_fire;
    logic [CNT_W-1:0]   sel_beats;

    // Number of beats in the request that starts at the selected requester.
    // Only Put messages carry more than one beat.
    function automatic logic [CNT_W-1:0] burst_beats(input logic [2:0] opcode,
                                                     input logic [2:0] size);
        int unsigned beats;
        beats = 1;
        if ((opcode == 3'd0 || opcode == 3'd1) && size >= 3'd3) begin
            beats = 32'd1 << (size - 3'd3);
            if (beats > MAX_BEATS) begin
                beats = MAX_BEATS;
            end
        end
        return CNT_W'(beats);
    endfunction

    // Grant selection. During a burst only the lock owner is considered.
    // In IDLE the descending loop leaves the lowest-ranked valid candidate
    // as the winner.
    always_comb begin
        sel_idx = '0;
        sel_hit = 1'b0;
        cand    = '0;
        if (state_q == ST_BURST) begin
            sel_idx = lock_idx_q;
            sel_hit = 1'b1;
        end else begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
`ifdef TL_ARB_FIXED_PRIO_EN
                cand = IDX_W'(k);
`else
                cand = IDX_W'((32'(rr_ptr_q) + 32'(k)) % N_REQ);
`endif
                if (req_a_valid_i[cand]) begin
                    sel_idx = cand;
                    sel_hit = 1'b1;
                end
            end
        end
    end

    assign mem_a_valid_o   = sel_hit & req_a_valid_i[sel_idx];
    assign a_fire          = mem_a_valid_o & mem_a_ready_i;
    assign mem_a_opcode_o  = a_opcode[sel_idx];
    assign mem_a_param_o   = a_param[sel_idx];
    assign mem_a_size_o    = a_size[sel_idx];
    assign mem_a_source_o  = {sel_idx, a_source[sel_idx]};
    assign mem_a_address_o = a_address[sel_idx];
    assign mem_a_mask_o    = a_mask[sel_idx];
    assign mem_a_data_o    = a_data[sel_idx];
    assign sel_beats       = burst_beats(a_opcode[sel_idx], a_size[sel_idx]);

    always_comb begin
        req_a_ready_o = '0;
        if (sel_hit) begin
            req_a_ready_o[sel_idx] = mem_a_ready_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        beat_cnt_d = beat_cnt_q;
`ifndef TL_ARB_FIXED_PRIO_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (a_fire) begin
`ifndef TL_ARB_FIXED_PRIO_EN
                    rr_ptr_d = (32'(sel_idx) == N_REQ - 1) ? '0 : sel_idx + 1'b1;
`endif
                    if (sel_beats > CNT_W'(1)) begin
                        state_d    = ST_BURST;
                        lock_idx_d = sel_idx;
                        beat_cnt_d = sel_beats - 1'b1;
                    end
                end
            end
            ST_BURST: begin
                // A beat with valid low leaves the lock and the count as they are.
                if (a_fire) begin
                    beat_cnt_d = beat_cnt_q - 1'b1;
                    if (beat_cnt_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            lock_idx_q <= '0;
            beat_cnt_q <= '0;
`ifndef TL_ARB_FIXED_PRIO_EN
            rr_ptr_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            beat_cnt_q <= beat_cnt_d;
`ifndef TL_ARB_FIXED_PRIO_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

    assign arb_busy_o = (state_q == ST_BURST);

    // D channel. A source whose index names no requester is accepted and
    // dropped, so a bad response cannot wedge the memory port.
    logic [IDX_W-1:0] d_idx;
    logic             d_hit;

    assign d_idx = mem_d_source_i[SRC_W-1 -: IDX_W];
    assign d_hit = (32'(d_idx) < N_REQ);

    always_comb begin
        req_d_valid_o = '0;
        mem_d_ready_o = 1'b1;
        if (d_hit) begin
            req_d_valid_o[d_idx] = mem_d_valid_i;
            mem_d_ready_o        = req_d_ready_i[d_idx];
        end
    end

    assign req_d_opcode_o  = mem_d_opcode_i;
    assign req_d_param_o   = mem_d_param_i;
    assign req_d_size_o    = mem_d_size_i;
    assign req_d_source_o  = mem_d_source_i[LSRC_W-1:0];
    assign req_d_sink_o    = mem_d_sink_i;
    assign req_d_denied_o  = mem_d_denied_i;
    assign req_d_data_o    = mem_d_data_i;
    assign req_d_corrupt_o = mem_d_corrupt_i;

endmodule

// File: tb/tb_tl_mem_port_arbiter.sv
module tb_tl_mem_port_arbiter;

    localparam int N_REQ     = 2;
    localparam int ADDR_W    = 64;
    localparam int DATA_W    = 64;
    localparam int SRC_W     = 4;
    localparam int MAX_BEATS = 8;
    localparam int IDX_W     = 1;
    localparam int LSRC_W    = SRC_W - IDX_W;
    localparam int MASK_W    = DATA_W / 8;

    logic clk_i = 1'b0;
    logic rst_ni;

    logic [N_REQ-1:0]        req_a_valid_i, req_a_ready_o;
    logic [N_REQ*3-1:0]      req_a_opcode_i, req_a_param_i, req_a_size_i;
    logic [N_REQ*LSRC_W-1:0] req_a_source_i;
    logic [N_REQ*ADDR_W-1:0] req_a_address_i;
    logic [N_REQ*MASK_W-1:0] req_a_mask_i;
    logic [N_REQ*DATA_W-1:0] req_a_data_i;

    logic              mem_a_valid_o, mem_a_ready_i;
    logic [2:0]        mem_a_opcode_o, mem_a_param_o, mem_a_size_o;
    logic [SRC_W-1:0]  mem_a_source_o;
    logic [ADDR_W-1:0] mem_a_address_o;
    logic [MASK_W-1:0] mem_a_mask_o;
    logic [DATA_W-1:0] mem_a_data_o;

    logic              mem_d_valid_i, mem_d_ready_o;
    logic [2:0]        mem_d_opcode_i, mem_d_size_i;
    logic [1:0]        mem_d_param_i, mem_d_sink_i;
    logic [SRC_W-1:0]  mem_d_source_i;
    logic              mem_d_denied_i, mem_d_corrupt_i;
    logic [DATA_W-1:0] mem_d_data_i;

    logic [N_REQ-1:0]  req_d_valid_o, req_d_ready_i;
    logic [2:0]        req_d_opcode_o, req_d_size_o;
    logic [1:0]        req_d_param_o, req_d_sink_o;
    logic [LSRC_W-1:0] req_d_source_o;
    logic              req_d_denied_o, req_d_corrupt_o;
    logic [DATA_W-1:0] req_d_data_o;
    logic              arb_busy_o;

    tl_mem_port_arbiter #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .SRC_W(SRC_W), .MAX_BEATS(MAX_BEATS)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_a_valid_i(req_a_valid_i), .req_a_ready_o(req_a_ready_o),
        .req_a_opcode_i(req_a_opcode_i), .req_a_param_i(req_a_param_i),
        .req_a_size_i(req_a_size_i), .req_a_source_i(req_a_source_i),
        .req_a_address_i(req_a_address_i), .req_a_mask_i(req_a_mask_i),
        .req_a_data_i(req_a_data_i),
        .mem_a_valid_o(mem_a_valid_o), .mem_a_ready_i(mem_a_ready_i),
        .mem_a_opcode_o(mem_a_opcode_o), .mem_a_param_o(mem_a_param_o),
        .mem_a_size_o(mem_a_size_o), .mem_a_source_o(mem_a_source_o),
        .mem_a_address_o(mem_a_address_o), .mem_a_mask_o(mem_a_mask_o),
        .mem_a_data_o(mem_a_data_o),
        .mem_d_valid_i(mem_d_valid_i), .mem_d_ready_o(mem_d_ready_o),
        .mem_d_opcode_i(mem_d_opcode_i), .mem_d_param_i(mem_d_param_i),
        .mem_d_size_i(mem_d_size_i), .mem_d_source_i(mem_d_source_i),
        .mem_d_sink_i(mem_d_sink_i), .mem_d_denied_i(mem_d_denied_i),
        .mem_d_data_i(mem_d_data_i), .mem_d_corrupt_i(mem_d_corrupt_i),
        .req_d_valid_o(req_d_valid_o), .req_d_ready_i(req_d_ready_i),
        .req_d_opcode_o(req_d_opcode_o), .req_d_param_o(req_d_param_o),
        .req_d_size_o(req_d_size_o), .req_d_source_o(req_d_source_o),
        .req_d_sink_o(req_d_sink_o), .req_d_denied_o(req_d_denied_o),
        .req_d_data_o(req_d_data_o), .req_d_corrupt_o(req_d_corrupt_o),
        .arb_busy_o(arb_busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: priority order kept as a list that is rotated after
    // every IDLE grant, plus the owner and remaining beats of an open burst.
    int prio_q[$];
    int m_lock;
    int m_left;

    function automatic void model_reset();
        prio_q.delete();
        for (int i = 0; i < N_REQ; i++) prio_q.push_back(i);
        m_lock = -1;
        m_left = 0;
    endfunction

    function automatic int model_beats(input int op, input int size);
        int nb;
        nb = 1;
        if ((op == 0 || op == 1) && size >= 3) begin
            nb = 2 ** (size - 3);
            if (nb > MAX_BEATS) nb = MAX_BEATS;
        end
        return nb;
    endfunction

    function automatic int model_sel(input logic [N_REQ-1:0] v);
        if (m_lock >= 0) return m_lock;
        foreach (prio_q[k]) if (v[prio_q[k]]) return prio_q[k];
        return -1;
    endfunction

    function automatic void model_fire(input int sel, input int op, input int size);
        int nb;
        if (m_lock >= 0) begin
            m_left--;
            if (m_left == 0) m_lock = -1;
        end else begin
            while (prio_q[0] != sel) prio_q.push_back(prio_q.pop_front());
            prio_q.push_back(prio_q.pop_front());
            nb = model_beats(op, size);
            if (nb > 1) begin
                m_lock = sel;
                m_left = nb - 1;
            end
        end
    endfunction

    task automatic clear_inputs();
        req_a_valid_i = '0; req_a_opcode_i = '0; req_a_param_i = '0;
        req_a_size_i = '0; req_a_source_i = '0; req_a_address_i = '0;
        req_a_mask_i = '1; req_a_data_i = '0; mem_a_ready_i = 1'b0;
        mem_d_valid_i = 1'b0; mem_d_opcode_i = '0; mem_d_param_i = '0;
        mem_d_size_i = '0; mem_d_source_i = '0; mem_d_sink_i = '0;
        mem_d_denied_i = 1'b0; mem_d_data_i = '0; mem_d_corrupt_i = 1'b0;
        req_d_ready_i = '0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        model_reset();
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [2:0] op,
                           input logic [2:0] size, input logic [2:0] src,
                           input logic [63:0] addr, input logic [63:0] data);
        req_a_valid_i[i]             = v;
        req_a_opcode_i[i*3 +: 3]     = op;
        req_a_size_i[i*3 +: 3]       = size;
        req_a_source_i[i*LSRC_W +: LSRC_W] = src;
        req_a_address_i[i*ADDR_W +: ADDR_W] = addr;
        req_a_data_i[i*DATA_W +: DATA_W]    = data;
    endtask

    typedef struct {
        logic [1:0] a_valid;
        logic       a_rdy;
        logic       e_a_valid;
        logic [1:0] e_a_ready;
        logic [3:0] e_a_src;
        logic       d_valid;
        logic [3:0] d_src;
        logic [1:0] d_rdy;
        logic [1:0] e_d_valid;
        logic       e_d_ready;
        logic [2:0] e_d_src;
    } vec_t;

    vec_t vecs[6];

    task automatic run_random(input int ncyc);
        int sel, r, didx;
        logic e_valid;
        logic [N_REQ-1:0] e_ready, e_dv;
        logic e_dr;
        for (int c = 0; c < ncyc; c++) begin
            for (int i = 0; i < N_REQ; i++) begin
                r = $urandom_range(0, 3);
                set_req(i, ($urandom_range(0, 3) != 0),
                        (r == 0) ? 3'd0 : (r == 1) ? 3'd1 : 3'd4,
                        3'($urandom_range(0, 7)), 3'($urandom),
                        {$urandom, $urandom}, {$urandom, $urandom});
            end
            mem_a_ready_i  = ($urandom_range(0, 3) != 0);
            mem_d_valid_i  = 1'($urandom);
            mem_d_source_i = 4'($urandom);
            mem_d_data_i   = {$urandom, $urandom};
            req_d_ready_i  = 2'($urandom);
            @(negedge clk_i);
            sel     = model_sel(req_a_valid_i);
            e_valid = (sel >= 0) && req_a_valid_i[sel];
            e_ready = (sel >= 0 && mem_a_ready_i) ? N_REQ'(1 << sel) : '0;
            chk("rnd_a_valid", mem_a_valid_o, e_valid);
            chk("rnd_a_ready", req_a_ready_o, e_ready);
            chk("rnd_busy", arb_busy_o, (m_lock >= 0));
            if (e_valid) begin
                chk("rnd_a_source", mem_a_source_o,
                    sel * (2 ** LSRC_W) + req_a_source_i[sel*LSRC_W +: LSRC_W]);
                chk("rnd_a_addr", mem_a_address_o, req_a_address_i[sel*ADDR_W +: ADDR_W]);
                chk("rnd_a_data", mem_a_data_o, req_a_data_i[sel*DATA_W +: DATA_W]);
            end
            didx = int'(mem_d_source_i) / (2 ** LSRC_W);
            e_dv = (didx < N_REQ && mem_d_valid_i) ? N_REQ'(1 << didx) : '0;
            e_dr = (didx < N_REQ) ? req_d_ready_i[didx] : 1'b1;
            chk("rnd_d_valid", req_d_valid_o, e_dv);
            chk("rnd_d_ready", mem_d_ready_o, e_dr);
            chk("rnd_d_source", req_d_source_o, int'(mem_d_source_i) % (2 ** LSRC_W));
            chk("rnd_d_data", req_d_data_o, mem_d_data_i);
            if (e_valid && mem_a_ready_i)
                model_fire(sel, int'(req_a_opcode_i[sel*3 +: 3]), int'(req_a_size_i[sel*3 +: 3]));
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int beat, cyc;
        logic v1;

        vecs[0] = '{2'b00, 1'b1, 1'b0, 2'b00, 4'h0, 1'b1, 4'b0000, 2'b11, 2'b01, 1'b1, 3'b000};
        vecs[1] = '{2'b01, 1'b1, 1'b1, 2'b01, 4'h3, 1'b1, 4'b0111, 2'b10, 2'b01, 1'b0, 3'b111};
        vecs[2] = '{2'b10, 1'b1, 1'b1, 2'b10, 4'hE, 1'b1, 4'b1000, 2'b01, 2'b10, 1'b0, 3'b000};
        vecs[3] = '{2'b11, 1'b1, 1'b1, 2'b01, 4'h3, 1'b1, 4'b1101, 2'b10, 2'b10, 1'b1, 3'b101};
        vecs[4] = '{2'b11, 1'b0, 1'b1, 2'b00, 4'h3, 1'b0, 4'b1011, 2'b11, 2'b00, 1'b1, 3'b011};
        vecs[5] = '{2'b10, 1'b0, 1'b1, 2'b00, 4'hE, 1'b0, 4'b0011, 2'b10, 2'b00, 1'b0, 3'b011};

        // Reset state with everything idle.
        do_reset();
        @(negedge clk_i);
        chk("rst_a_valid", mem_a_valid_o, 1'b0);
        chk("rst_a_ready", req_a_ready_o, 2'b00);
        chk("rst_d_valid", req_d_valid_o, 2'b00);
        chk("rst_busy", arb_busy_o, 1'b0);

        // Table: first-cycle grant after reset plus stateless D routing.
        foreach (vecs[n]) begin
            do_reset();
            set_req(0, vecs[n].a_valid[0], 3'd4, 3'd2, 3'b011, 64'h100, 64'h0);
            set_req(1, vecs[n].a_valid[1], 3'd4, 3'd2, 3'b110, 64'h200, 64'h0);
            mem_a_ready_i  = vecs[n].a_rdy;
            mem_d_valid_i  = vecs[n].d_valid;
            mem_d_source_i = vecs[n].d_src;
            req_d_ready_i  = vecs[n].d_rdy;
            @(negedge clk_i);
            chk("vec_a_valid", mem_a_valid_o, vecs[n].e_a_valid);
            chk("vec_a_ready", req_a_ready_o, vecs[n].e_a_ready);
            if (vecs[n].e_a_valid) chk("vec_a_source", mem_a_source_o, vecs[n].e_a_src);
            chk("vec_d_valid", req_d_valid_o, vecs[n].e_d_valid);
            chk("vec_d_ready", mem_d_ready_o, vecs[n].e_d_ready);
            chk("vec_d_source", req_d_source_o, vecs[n].e_d_src);
        end

        // Two contending Gets: round-robin order 0, 1, 0.
        do_reset();
        set_req(0, 1'b1, 3'd4, 3'd6, 3'b000, 64'h100, 64'h0);
        set_req(1, 1'b1, 3'd4, 3'd6, 3'b101, 64'h200, 64'h0);
        mem_a_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            chk("rr_ready", req_a_ready_o, (k == 1) ? 2'b10 : 2'b01);
            chk("rr_addr", mem_a_address_o, (k == 1) ? 64'h200 : 64'h100);
            chk("rr_source", mem_a_source_o, (k == 1) ? 4'hD : 4'h0);
            step();
        end

        // 8-beat PutFullData from req1 while req0 keeps requesting.
        do_reset();
        set_req(0, 1'b1, 3'd4, 3'd6, 3'b000, 64'h100, 64'h0);
        mem_a_ready_i = 1'b1;
        @(negedge clk_i);
        chk("burst_prime", req_a_ready_o, 2'b01);
        step();
        for (int k = 0; k < 8; k++) begin
            set_req(1, 1'b1, 3'd0, 3'd6, 3'b010, 64'h400, 64'(k));
            @(negedge clk_i);
            chk("burst_ready", req_a_ready_o, 2'b10);
            chk("burst_source", mem_a_source_o, 4'b1010);
            chk("burst_data", mem_a_data_o, 64'(k));
            // Lock is taken by the first beat, so busy shows from beat 2 on.
            chk("burst_busy", arb_busy_o, (k != 0));
            step();
        end
        @(negedge clk_i);
        chk("burst_after_ready", req_a_ready_o, 2'b01);
        chk("burst_after_busy", arb_busy_o, 1'b0);
        step();

        // Same burst with a 3-cycle valid bubble and toggling memory ready.
        do_reset();
        set_req(0, 1'b1, 3'd4, 3'd6, 3'b000, 64'h100, 64'h0);
        mem_a_ready_i = 1'b1;
        step();
        beat = 0;
        cyc  = 0;
        while (beat < 8 && cyc < 60) begin
            v1 = !(cyc >= 4 && cyc < 7);
            mem_a_ready_i = (cyc % 2 == 0);
            set_req(1, v1, 3'd0, 3'd6, 3'b010, 64'h400, 64'(beat));
            @(negedge clk_i);
            chk("bubble_req0_blocked", req_a_ready_o[0], 1'b0);
            chk("bubble_valid", mem_a_valid_o, v1);
            if (cyc > 0) chk("bubble_busy", arb_busy_o, 1'b1);
            if (v1 && mem_a_ready_i) begin
                chk("bubble_data", mem_a_data_o, 64'(beat));
                beat++;
            end
            step();
            cyc++;
        end
        chk("bubble_all_beats", beat, 8);
        set_req(1, 1'b0, 3'd4, 3'd0, 3'b000, 64'h0, 64'h0);
        mem_a_ready_i = 1'b1;
        @(negedge clk_i);
        chk("bubble_after_ready", req_a_ready_o, 2'b01);
        chk("bubble_after_busy", arb_busy_o, 1'b0);

        // D channel: AccessAckData to requester 1, local source 3'b010.
        clear_inputs();
        for (int k = 0; k < 8; k++) begin
            mem_d_valid_i  = 1'b1;
            mem_d_opcode_i = 3'd1;
            mem_d_source_i = 4'b1010;
            mem_d_data_i   = 64'(k) * 64'h1111;
            req_d_ready_i  = (k % 3 == 1) ? 2'b01 : 2'b10;
            @(negedge clk_i);
            chk("d_valid", req_d_valid_o, 2'b10);
            chk("d_source", req_d_source_o, 3'b010);
            chk("d_ready", mem_d_ready_o, (k % 3 != 1));
            chk("d_data", req_d_data_o, 64'(k) * 64'h1111);
            chk("d_opcode", req_d_opcode_o, 3'd1);
            step();
        end

        // Reset asserted at beat 4 of a burst.
        do_reset();
        mem_a_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_req(0, 1'b1, 3'd0, 3'd6, 3'b000, 64'h800, 64'(k));
            step();
        end
        @(negedge clk_i);
        chk("midrst_busy_before", arb_busy_o, 1'b1);
        #2 rst_ni = 1'b0;
        #1;
        chk("midrst_busy_in_reset", arb_busy_o, 1'b0);
        set_req(0, 1'b1, 3'd4, 3'd6, 3'b000, 64'h100, 64'h0);
        set_req(1, 1'b1, 3'd4, 3'd6, 3'b001, 64'h200, 64'h0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        chk("midrst_ready", req_a_ready_o, 2'b01);
        chk("midrst_addr", mem_a_address_o, 64'h100);
        chk("midrst_busy", arb_busy_o, 1'b0);
        step();
        @(negedge clk_i);
        chk("midrst_next_ready", req_a_ready_o, 2'b10);

        // Randomized traffic against the reference model.
        do_reset();
        run_random(2000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
